core2axi4l: RTL and testbench
=============================

// Module: core2axi4l
// PURPOSE
//  Bridges an Ibex-style core memory port (req/gnt/rvalid) to an AXI4-Lite manager.
//  Sits between an Ibex LSU or instruction-fetch port and the AXI4-Lite interconnect.
//  It performs the inverse conversion of the AXI4-Lite-to-core slave bridge.
//  At most one transaction is outstanding; AW and W are issued together; responses return as a one-cycle core.rvalid.
// PARAMETERS
//  ADDR_WIDTH  32      core.addr / awaddr / araddr width
//  DATA_WIDTH  32      wdata/rdata width; be/wstrb width = DATA_WIDTH/8
//  AXPROT      3'b000  constant driven on awprot/arprot (instruction port: 3'b100)
// PORTS
//  aclk         in   1      single clock for core and AXI sides
//  aresetn      in   1      asynchronous, active-low reset
//  core.req     in   1      core request; held with addr/we/be/wdata until gnt
//  core.gnt     out  1      request accepted this cycle
//  core.addr    in   AW     byte address
//  core.we      in   1      1 = write
//  core.be      in   DW/8   byte enables
//  core.wdata   in   DW     write data
//  core.rvalid  out  1      response pulse (one per granted request)
//  core.rdata   out  DW     read data, valid with rvalid; 0 for writes
//  core.err     out  1      bus error, valid with rvalid
//  axi.aw*/w*/b*/ar*/r*     AXI4-Lite manager channels (valid/ready, addr, prot, data, strb, resp)
// BEHAVIOUR
//  Reset: all AXI valids, bready, rready, core.gnt, core.rvalid and core.err are 0.
//    Reset: core.rdata is 0; state is IDLE.
//  States: IDLE, READ, READ_WAIT, WRITE, WRITE_WAIT, RESP.
//  IDLE:
//    - core.gnt = core.req (combinational).
//    - On req&&gnt, register addr/be/wdata and go to READ (we=0) or WRITE (we=1).
//  READ:
//    - arvalid=1 with araddr=registered addr; rready=1.
//    - On arready, go to READ_WAIT.
//    - If rvalid coincides with arready, go directly to RESP.
//  READ_WAIT:
//    - rready=1.
//    - On rvalid, capture rdata and err=rresp[1], then go to RESP.
//  WRITE:
//    - awvalid and wvalid both assert on entry.
//    - Each drops independently after its own handshake (flags aw_done, w_done).
//    - bready=1.
//    - When both handshakes are done, go to WRITE_WAIT.
//    - A B handshake cannot occur before both are done.
//  WRITE_WAIT:
//    - bready=1.
//    - On bvalid, err=bresp[1], rdata=0, go to RESP.
//  RESP:
//    - core.rvalid=1 for exactly one cycle; rdata/err hold until the next response.
//    - Always return to IDLE; gnt is available in the same cycle as rvalid+1.
//  Latency:
//    - gnt in cycle 0; ar/aw/w valid in cycle 1.
//    - Response handshake at N gives core.rvalid at N+1.
//  AXI stability: valid/addr/prot/data/strb are registered; they never change while valid && !ready.
//  wstrb = be; awprot = arprot = AXPROT; addr is passed unmodified (no alignment).
//  DECERR and SLVERR both give err=1; OKAY and EXOKAY give err=0.
//  No new gnt is issued until the current response is delivered, so there is never more than 1 outstanding.
//  Mid-transfer reset: all outputs return to reset values immediately; the pending response is dropped.
// STRUCTURE
//  axi4l_pkg: resp_t (OKAY, EXOKAY, SLVERR, DECERR); add EXOKAY/DECERR if absent.
//  state_t is a local enum in core2axi4l (the FSM is private to this block).
//  No sub-module; a single FSM plus capture registers.
// TESTING
//  - Read, arready=1, rvalid 2 cycles later, rdata=32'hDEADBEEF, OKAY
//      -> rvalid=1 once, rdata=DEADBEEF, err=0.
//  - Write 32'h12345678, be=4'b0110, wready 3 cycles before awready, bresp=OKAY
//      -> wstrb=0110, each valid drops after own handshake, one rvalid, err=0.
//  - Read with rresp=SLVERR, then write with bresp=DECERR -> err=1 on both rvalid pulses.
//  - Back-to-back req held high for 4 reads
//      -> exactly 4 gnts, each gnt after previous rvalid, never two ARs outstanding.
//  - arready=0 for 10 cycles -> arvalid/araddr/arprot stable throughout.
//  - aresetn low during WRITE_WAIT -> all valids/gnt/rvalid low asynchronously; no stray rvalid after release.
//  - Formal: AXI manager stability/reset properties; core rvalid count equals gnt count.

Source files
------------

// File: rtl/core2axi4l_pkg.sv
// Shared AXI4-Lite response encodings and helpers for the core-to-AXI4-Lite bridge.
package core2axi4l_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam logic [2:0]  PROT_DATA      = 3'b000;
    localparam logic [2:0]  PROT_INSTR     = 3'b100;

    // Both error encodings collapse onto the single core error bit.
    function automatic logic resp_is_err(input resp_t r);
        return (r == RESP_SLVERR) || (r == RESP_DECERR);
    endfunction

endpackage

// File: rtl/core2axi4l_if.sv
// Core memory port (req/gnt/rvalid) and AXI4-Lite bus bundles used by the bridge.
interface core_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          gnt;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW/8-1:0] be;
    logic [DW-1:0] wdata;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

interface axi4l_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/core2axi4l.sv
// Bridges an Ibex-style req/gnt/rvalid memory port onto an AXI4-Lite manager,
// one transaction in flight at a time.
module core2axi4l
    import core2axi4l_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] AXPROT     = 3'b000
) (
    input  logic     aclk,
    input  logic     aresetn,
    core_mem_if.slave core,
    axi4l_if.master   axi
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        READ_WAIT,
        WRITE,
        WRITE_WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] be_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    aw_done;
    logic                    w_done;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic ar_hs;
    logic r_hs;
    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;

    assign ar_hs  = arvalid_q && axi.arready;
    assign r_hs   = rready_q && axi.rvalid;
    assign aw_hs  = awvalid_q && axi.awready;
    assign w_hs   = wvalid_q && axi.wready;
    assign aw_fin = aw_done || aw_hs;
    assign w_fin  = w_done || w_hs;

    // Gating with aresetn keeps gnt low while reset is asserted even if req is high.
    assign core.gnt    = aresetn && (state == IDLE) && core.req;
    assign core.rvalid = rvalid_q;
    assign core.rdata  = rdata_q;
    assign core.err    = err_q;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awprot  = AXPROT;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = be_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = AXPROT;
    assign axi.rready  = rready_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (core.req) begin
                        addr_q  <= core.addr;
                        be_q    <= core.be;
                        wdata_q <= core.wdata;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (core.we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            bready_q  <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            arvalid_q <= 1'b1;
                            rready_q  <= 1'b1;
                            state     <= READ;
                        end
                    end
                end

                READ: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        if (r_hs) begin
                            rdata_q  <= axi.rdata;
                            err_q    <= resp_is_err(resp_t'(axi.rresp));
                            rready_q <= 1'b0;
                            rvalid_q <= 1'b1;
                            state    <= RESP;
                        end else begin
                            state <= READ_WAIT;
                        end
                    end
                end

                READ_WAIT: begin
                    if (r_hs) begin
                        rdata_q  <= axi.rdata;
                        err_q    <= resp_is_err(resp_t'(axi.rresp));
                        rready_q <= 1'b0;
                        rvalid_q <= 1'b1;
                        state    <= RESP;
                    end
                end

                // AW and W complete independently; the flags remember which side is already done.
                WRITE: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        state <= WRITE_WAIT;
                    end
                end

                WRITE_WAIT: begin
                    if (axi.bvalid) begin
                        rdata_q  <= '0;
                        err_q    <= resp_is_err(resp_t'(axi.bresp));
                        bready_q <= 1'b0;
                        rvalid_q <= 1'b1;
                        state    <= RESP;
                    end
                end

                RESP: begin
                    rvalid_q <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core2axi4l.sv
// Directed self-checking bench for core2axi4l; the bench plays both the core and the AXI subordinate.
module tb_core2axi4l;
    import core2axi4l_pkg::*;

    logic aclk = 1'b0;
    logic aresetn;

    always #5 aclk = ~aclk;

    core_mem_if #(.AW(32), .DW(32)) core_bus ();
    axi4l_if    #(.AW(32), .DW(32)) axi_bus ();

    core2axi4l #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .AXPROT    (3'b000)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .core   (core_bus),
        .axi    (axi_bus)
    );

    int tests = 0;
    int fails = 0;

    int gnt_cnt     = 0;
    int rv_cnt      = 0;
    int outstanding = 0;
    int ar_out      = 0;
    int viol        = 0;

    // Protocol monitor: counts grants/responses and flags a second grant or AR while one is pending.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding <= 0;
            ar_out      <= 0;
        end else begin
            gnt_cnt     <= gnt_cnt + int'(core_bus.req && core_bus.gnt);
            rv_cnt      <= rv_cnt + int'(core_bus.rvalid);
            outstanding <= outstanding + int'(core_bus.req && core_bus.gnt) - int'(core_bus.rvalid);
            ar_out      <= ar_out + int'(axi_bus.arvalid && axi_bus.arready)
                                  - int'(axi_bus.rvalid && axi_bus.rready);
            viol        <= viol + int'(core_bus.req && core_bus.gnt && outstanding != 0)
                                + int'(axi_bus.arvalid && axi_bus.arready && ar_out != 0);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        core_bus.req   = 1'b0;
        core_bus.addr  = '0;
        core_bus.we    = 1'b0;
        core_bus.be    = '0;
        core_bus.wdata = '0;
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        axi_bus.bvalid  = 1'b0;
        axi_bus.bresp   = 2'b00;
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b0;
        axi_bus.rdata   = '0;
        axi_bus.rresp   = 2'b00;
    endtask

    task automatic wait_gnt(output bit to);
        to = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (core_bus.gnt) begin
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    // Returns with the bridge in its response cycle.
    task automatic read_txn(input logic [31:0] a, input int ar_dly, input int r_dly,
                            input logic [31:0] d, input logic [1:0] resp, output bit to);
        core_bus.req  = 1'b1;
        core_bus.we   = 1'b0;
        core_bus.addr = a;
        core_bus.be   = 4'hF;
        wait_gnt(to);
        tick();
        core_bus.req = 1'b0;
        repeat (ar_dly) tick();
        axi_bus.arready = 1'b1;
        tick();
        axi_bus.arready = 1'b0;
        repeat (r_dly) tick();
        axi_bus.rvalid = 1'b1;
        axi_bus.rdata  = d;
        axi_bus.rresp  = resp;
        tick();
        axi_bus.rvalid = 1'b0;
        axi_bus.rdata  = '0;
        axi_bus.rresp  = 2'b00;
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] resp, output bit to);
        core_bus.req   = 1'b1;
        core_bus.we    = 1'b1;
        core_bus.addr  = a;
        core_bus.wdata = d;
        core_bus.be    = be;
        wait_gnt(to);
        tick();
        core_bus.req = 1'b0;
        for (int k = 0; k <= ((aw_dly > w_dly) ? aw_dly : w_dly); k++) begin
            axi_bus.awready = (k == aw_dly);
            axi_bus.wready  = (k == w_dly);
            tick();
        end
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        repeat (b_dly) tick();
        axi_bus.bvalid = 1'b1;
        axi_bus.bresp  = resp;
        tick();
        axi_bus.bvalid = 1'b0;
        axi_bus.bresp  = 2'b00;
    endtask

    task automatic test_reset();
        logic [7:0] ctl;
        idle_inputs();
        aresetn      = 1'b0;
        core_bus.req = 1'b1;
        tick();
        tick();
        ctl = {core_bus.gnt, axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid,
               axi_bus.bready, axi_bus.rready, core_bus.rvalid, core_bus.err};
        tests++;
        if (ctl !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_ctl: got %b, want %b", ctl, 8'h00);
        end
        tests++;
        if (core_bus.rdata !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_rdata: got %h, want %h", core_bus.rdata, 32'h0);
        end
        core_bus.req = 1'b0;
        aresetn      = 1'b1;
        tick();
    endtask

    task automatic test_read();
        bit to;
        int r0 = rv_cnt;
        read_txn(32'h1000_0004, 0, 1, 32'hDEAD_BEEF, RESP_OKAY, to);
        tests++;
        if (to !== 1'b0) begin
            fails++;
            $display("[TB] FAIL read_gnt_timeout: got %b, want %b", to, 1'b0);
        end
        tests++;
        if ({core_bus.rvalid, core_bus.err, core_bus.rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            fails++;
            $display("[TB] FAIL read_resp: got rvalid=%b err=%b rdata=%h, want 1 0 deadbeef",
                     core_bus.rvalid, core_bus.err, core_bus.rdata);
        end
        tick();
        tests++;
        if ({core_bus.rvalid, core_bus.rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            fails++;
            $display("[TB] FAIL read_hold: got rvalid=%b rdata=%h, want 0 deadbeef",
                     core_bus.rvalid, core_bus.rdata);
        end
        tests++;
        if (rv_cnt - r0 !== 1) begin
            fails++;
            $display("[TB] FAIL read_pulse_count: got %0d, want %0d", rv_cnt - r0, 1);
        end
    endtask

    task automatic test_write();
        bit to;
        core_bus.req   = 1'b1;
        core_bus.we    = 1'b1;
        core_bus.addr  = 32'h2000_0010;
        core_bus.wdata = 32'h1234_5678;
        core_bus.be    = 4'b0110;
        wait_gnt(to);
        tests++;
        if (to !== 1'b0) begin
            fails++;
            $display("[TB] FAIL write_gnt_timeout: got %b, want %b", to, 1'b0);
        end
        tick();
        core_bus.req = 1'b0;
        tests++;
        if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.wstrb, axi_bus.wdata, axi_bus.awaddr, axi_bus.awprot}
            !== {1'b1, 1'b1, 1'b1, 4'b0110, 32'h1234_5678, 32'h2000_0010, 3'b000}) begin
            fails++;
            $display("[TB] FAIL write_issue: got aw=%b w=%b b=%b strb=%b data=%h addr=%h prot=%b, want 1 1 1 0110 12345678 20000010 000",
                     axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.wstrb,
                     axi_bus.wdata, axi_bus.awaddr, axi_bus.awprot);
        end
        axi_bus.wready = 1'b1;
        tick();
        axi_bus.wready = 1'b0;
        tests++;
        if ({axi_bus.awvalid, axi_bus.wvalid} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL write_w_drop: got aw,w=%b, want %b", {axi_bus.awvalid, axi_bus.wvalid}, 2'b10);
        end
        tick();
        tick();
        axi_bus.awready = 1'b1;
        tick();
        axi_bus.awready = 1'b0;
        tests++;
        if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready} !== 3'b001) begin
            fails++;
            $display("[TB] FAIL write_aw_drop: got aw,w,b=%b, want %b",
                     {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}, 3'b001);
        end
        axi_bus.bvalid = 1'b1;
        axi_bus.bresp  = RESP_OKAY;
        tick();
        axi_bus.bvalid = 1'b0;
        tests++;
        if ({core_bus.rvalid, core_bus.err, core_bus.rdata} !== {1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("[TB] FAIL write_resp: got rvalid=%b err=%b rdata=%h, want 1 0 00000000",
                     core_bus.rvalid, core_bus.err, core_bus.rdata);
        end
        tick();
        tests++;
        if (core_bus.rvalid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL write_pulse_end: got %b, want %b", core_bus.rvalid, 1'b0);
        end
    endtask

    task automatic test_errors();
        bit to;
        read_txn(32'h1000_0100, 1, 0, 32'h55AA_55AA, RESP_SLVERR, to);
        tests++;
        if ({to, core_bus.rvalid, core_bus.err, core_bus.rdata} !== {1'b0, 1'b1, 1'b1, 32'h55AA_55AA}) begin
            fails++;
            $display("[TB] FAIL err_slverr: got to=%b rvalid=%b err=%b rdata=%h, want 0 1 1 55aa55aa",
                     to, core_bus.rvalid, core_bus.err, core_bus.rdata);
        end
        tick();
        write_txn(32'h2000_0200, 32'hCAFE_F00D, 4'b1111, 1, 0, 1, RESP_DECERR, to);
        tests++;
        if ({to, core_bus.rvalid, core_bus.err, core_bus.rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
            fails++;
            $display("[TB] FAIL err_decerr: got to=%b rvalid=%b err=%b rdata=%h, want 0 1 1 00000000",
                     to, core_bus.rvalid, core_bus.err, core_bus.rdata);
        end
        tick();
        read_txn(32'h1000_0200, 0, 0, 32'h0BAD_CAFE, RESP_EXOKAY, to);
        tests++;
        if ({to, core_bus.rvalid, core_bus.err, core_bus.rdata} !== {1'b0, 1'b1, 1'b0, 32'h0BAD_CAFE}) begin
            fails++;
            $display("[TB] FAIL err_exokay: got to=%b rvalid=%b err=%b rdata=%h, want 0 1 0 0badcafe",
                     to, core_bus.rvalid, core_bus.err, core_bus.rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int g0 = gnt_cnt;
        int r0 = rv_cnt;
        int v0 = viol;
        int nar = 0;
        bit pend = 1'b0;
        core_bus.req    = 1'b1;
        core_bus.we     = 1'b0;
        core_bus.addr   = 32'h3000_0000;
        core_bus.be     = 4'hF;
        axi_bus.arready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (rv_cnt - r0 >= 4) break;
            axi_bus.rvalid = pend;
            axi_bus.rdata  = 32'hB000_0000 + 32'(nar);
            axi_bus.rresp  = RESP_OKAY;
            pend = axi_bus.arvalid;
            if (axi_bus.arvalid) nar++;
            tick();
        end
        core_bus.req    = 1'b0;
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b0;
        tests++;
        if (gnt_cnt - g0 !== 4) begin
            fails++;
            $display("[TB] FAIL b2b_gnts: got %0d, want %0d", gnt_cnt - g0, 4);
        end
        tests++;
        if (rv_cnt - r0 !== 4) begin
            fails++;
            $display("[TB] FAIL b2b_rvalids: got %0d, want %0d", rv_cnt - r0, 4);
        end
        tests++;
        if (viol - v0 !== 0) begin
            fails++;
            $display("[TB] FAIL b2b_outstanding: got %0d violations, want %0d", viol - v0, 0);
        end
        tests++;
        if (core_bus.rdata !== 32'hB000_0004) begin
            fails++;
            $display("[TB] FAIL b2b_last_data: got %h, want %h", core_bus.rdata, 32'hB000_0004);
        end
        tick();
    endtask

    task automatic test_ar_stall();
        bit to;
        core_bus.req  = 1'b1;
        core_bus.we   = 1'b0;
        core_bus.addr = 32'h0000_0ABC;
        wait_gnt(to);
        tick();
        core_bus.req  = 1'b0;
        core_bus.addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            tests++;
            if ({axi_bus.arvalid, axi_bus.araddr, axi_bus.arprot} !== {1'b1, 32'h0000_0ABC, 3'b000}) begin
                fails++;
                $display("[TB] FAIL ar_stable[%0d]: got v=%b addr=%h prot=%b, want 1 00000abc 000",
                         i, axi_bus.arvalid, axi_bus.araddr, axi_bus.arprot);
            end
            tick();
        end
        axi_bus.arready = 1'b1;
        tick();
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b1;
        axi_bus.rdata   = 32'hC0FF_EE00;
        axi_bus.rresp   = RESP_OKAY;
        tick();
        axi_bus.rvalid = 1'b0;
        tests++;
        if ({to, core_bus.rvalid, core_bus.rdata} !== {1'b0, 1'b1, 32'hC0FF_EE00}) begin
            fails++;
            $display("[TB] FAIL ar_stall_resp: got to=%b rvalid=%b rdata=%h, want 0 1 c0ffee00",
                     to, core_bus.rvalid, core_bus.rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit to;
        int r0;
        logic [7:0] ctl;
        core_bus.req   = 1'b1;
        core_bus.we    = 1'b1;
        core_bus.addr  = 32'h4000_0000;
        core_bus.wdata = 32'hA5A5_A5A5;
        core_bus.be    = 4'hF;
        wait_gnt(to);
        tick();
        core_bus.req    = 1'b0;
        axi_bus.awready = 1'b1;
        axi_bus.wready  = 1'b1;
        tick();
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        tests++;
        if ({to, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready} !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL midrst_setup: got to,aw,w,b=%b, want %b",
                     {to, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}, 4'b0001);
        end
        r0 = rv_cnt;
        core_bus.req = 1'b1;
        core_bus.we  = 1'b0;
        aresetn      = 1'b0;
        #1;
        ctl = {core_bus.gnt, axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid,
               axi_bus.bready, axi_bus.rready, core_bus.rvalid, core_bus.err};
        tests++;
        if (ctl !== 8'h00) begin
            fails++;
            $display("[TB] FAIL midrst_async: got %b, want %b", ctl, 8'h00);
        end
        axi_bus.bvalid = 1'b1;
        tick();
        tick();
        axi_bus.bvalid = 1'b0;
        core_bus.req   = 1'b0;
        aresetn        = 1'b1;
        repeat (5) tick();
        tests++;
        if (rv_cnt - r0 !== 0) begin
            fails++;
            $display("[TB] FAIL midrst_stray_rvalid: got %0d pulses, want %0d", rv_cnt - r0, 0);
        end
        core_bus.req = 1'b1;
        #1;
        tests++;
        if (core_bus.gnt !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midrst_idle_gnt: got %b, want %b", core_bus.gnt, 1'b1);
        end
        core_bus.req = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        aresetn = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_errors();
        test_back_to_back();
        test_ar_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
